// File: rtl/adder_pipe_param.sv
// Pipelined adder/subtractor: the carry ripples one STG_WIDTH slice per stage
// under a valid/ready handshake with a single global advance.
module adder_pipe_param #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned STG_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic                  i_sub,
    input  logic [DATA_WIDTH-1:0] adda,
    input  logic [DATA_WIDTH-1:0] addb,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH:0]   result,
    output logic                  o_ovf
);
    localparam int W    = int'(DATA_WIDTH);
    localparam int S    = int'(STG_WIDTH);
    localparam int NSTG = W / S;

    logic         adv;
    logic [W-1:0] b_inv;
    logic         o_valid_q;
    logic         ovf_q;
    logic [W:0]   res_q;

    assign adv     = !o_valid_q || o_ready;
    assign i_ready = adv;
    assign b_inv   = i_sub ? ~addb : addb;
    assign o_valid = o_valid_q;
    assign result  = res_q;
    assign o_ovf   = ovf_q;

    // Stage k adds slice k; each stage keeps only the operand slices still to be
    // added and the sum slices already produced, so nothing is carried unused.
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [W-1:k*S]     a_in;
        logic [W-1:k*S]     b_in;
        logic               c_in;
        logic               v_in;
        logic [(k+1)*S-1:0] sum_d;
        logic [S:0]         slc;

        assign slc = {1'b0, a_in[k*S +: S]} + {1'b0, b_in[k*S +: S]} + {{S{1'b0}}, c_in};

        if (k == 0) begin : g_head
            assign a_in  = adda;
            assign b_in  = b_inv;
            assign c_in  = i_sub;
            assign v_in  = i_valid;
            assign sum_d = slc[S-1:0];
        end else begin : g_link
            assign a_in  = g_stg[k-1].g_mid.a_q;
            assign b_in  = g_stg[k-1].g_mid.b_q;
            assign c_in  = g_stg[k-1].g_mid.c_q;
            assign v_in  = g_stg[k-1].g_mid.v_q;
            assign sum_d = {slc[S-1:0], g_stg[k-1].g_mid.s_q};
        end

        if (k < NSTG - 1) begin : g_mid
            logic [W-1:(k+1)*S] a_q;
            logic [W-1:(k+1)*S] b_q;
            logic [(k+1)*S-1:0] s_q;
            logic               c_q;
            logic               v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q <= v_in;
                    if (v_in) begin
                        a_q <= a_in[W-1:(k+1)*S];
                        b_q <= b_in[W-1:(k+1)*S];
                        s_q <= sum_d;
                        c_q <= slc[S];
                    end
                end
            end
        end else begin : g_last
            // The final stage is the output register; bubbles never overwrite it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_valid_q <= 1'b0;
                    res_q     <= '0;
                    ovf_q     <= 1'b0;
                end else if (adv) begin
                    o_valid_q <= v_in;
                    if (v_in) begin
                        res_q <= {slc[S], sum_d};
                        ovf_q <= (a_in[W-1] == b_in[W-1]) && (slc[S-1] != a_in[W-1]);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_pipe_param.sv
// Scoreboard bench for adder_pipe_param: a 64/16 instance and a degenerate
// 16/16 instance, each with its own expected-result queue and monitor.
module tb_adder_pipe_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_valid, i_ready, i_sub, o_valid, o_ready, o_ovf;
    logic [63:0] adda, addb;
    logic [64:0] result;

    logic        d_i_valid, d_i_ready, d_i_sub, d_o_valid, d_o_ready, d_o_ovf;
    logic [15:0] d_adda, d_addb;
    logic [16:0] d_result;

    adder_pipe_param #(.DATA_WIDTH(64), .STG_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_sub(i_sub),
        .adda(adda), .addb(addb), .o_valid(o_valid), .o_ready(o_ready),
        .result(result), .o_ovf(o_ovf)
    );

    adder_pipe_param #(.DATA_WIDTH(16), .STG_WIDTH(16)) dut_d (
        .clk(clk), .rst(rst), .i_valid(d_i_valid), .i_ready(d_i_ready), .i_sub(d_i_sub),
        .adda(d_adda), .addb(d_addb), .o_valid(d_o_valid), .o_ready(d_o_ready),
        .result(d_result), .o_ovf(d_o_ovf)
    );

    typedef struct {
        logic [64:0] res;
        logic        ovf;
        int          exp_cyc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    exp_t dq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   vcnt   = 0;
    bit   bp_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [65:0] model(input logic sub, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] r;
        logic        ov;
        if (!sub) begin
            r  = {1'b0, a} + {1'b0, b};
            ov = (a[63] == b[63]) && (r[63] != a[63]);
        end else begin
            r  = {(a >= b), a - b};
            ov = (a[63] != b[63]) && (r[63] != a[63]);
        end
        return {ov, r};
    endfunction

    initial begin
        o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic sub, input logic [63:0] a, input logic [63:0] b,
                        input logic [64:0] er, input logic eo, input bit lat);
        bit   acc = 1'b0;
        exp_t e;
        i_valid = 1'b1;
        i_sub   = sub;
        adda    = a;
        addb    = b;
        for (int g = 0; g < 200 && !acc; g++) begin
            @(negedge clk);
            if (i_ready) begin
                e.res = er; e.ovf = eo; e.exp_cyc = cyc + 4; e.lat = lat;
                q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 65'(0), 65'(1));
    endtask

    task automatic send_rand();
        logic [63:0] a, b;
        logic        s;
        logic [65:0] m;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        s = 1'($urandom_range(0, 1));
        m = model(s, a, b);
        send(s, a, b, m[64:0], m[65], 1'b0);
    endtask

    task automatic dsend(input logic sub, input logic [15:0] a, input logic [15:0] b,
                         input logic [16:0] er, input logic eo);
        bit   acc = 1'b0;
        exp_t e;
        d_i_valid = 1'b1;
        d_i_sub   = sub;
        d_adda    = a;
        d_addb    = b;
        for (int g = 0; g < 200 && !acc; g++) begin
            @(negedge clk);
            if (d_i_ready) begin
                e.res = 65'(er); e.ovf = eo; e.exp_cyc = cyc + 1; e.lat = 1'b1;
                dq.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("d_accept_timeout", 65'(0), 65'(1));
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int g = 0; g < 500 && (q.size() != 0 || dq.size() != 0); g++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_main", 65'(q.size()), 65'(0));
        chk("drain_degen", 65'(dq.size()), 65'(0));
    endtask

    logic [64:0] hold_res, last_res;
    logic        hold_ovf;
    bit          prev_hold = 1'b0;
    bit          have_last = 1'b0;
    int          first_seen = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_hold = 1'b0;
            have_last = 1'b0;
        end else begin
            chk("i_ready", 65'(i_ready), 65'(!o_valid || o_ready));
            if (prev_hold) begin
                chk("stall_valid", 65'(o_valid), 65'(1));
                chk("stall_result", result, hold_res);
                chk("stall_ovf", 65'(o_ovf), 65'(hold_ovf));
            end
            if (!o_valid && have_last) chk("bubble_hold", result, last_res);
            if (o_valid) begin
                vcnt++;
                if (!prev_hold) first_seen = cyc;
            end
            if (o_valid && o_ready) begin
                chk("output_expected", 65'(q.size() != 0), 65'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("o_ovf", 65'(o_ovf), 65'(e.ovf));
                    if (e.lat) chk("latency", 65'(first_seen), 65'(e.exp_cyc));
                    last_res  = result;
                    have_last = 1'b1;
                end
            end
            prev_hold = o_valid && !o_ready;
            hold_res  = result;
            hold_ovf  = o_ovf;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && d_o_valid && d_o_ready) begin
            chk("d_output_expected", 65'(dq.size() != 0), 65'(1));
            if (dq.size() != 0) begin
                e = dq.pop_front();
                chk("d_result", 65'(d_result), e.res);
                chk("d_o_ovf", 65'(d_o_ovf), 65'(e.ovf));
                chk("d_latency", 65'(cyc), 65'(e.exp_cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        i_valid = 1'b0; i_sub = 1'b0; adda = '0; addb = '0;
        d_i_valid = 1'b0; d_i_sub = 1'b0; d_adda = '0; d_addb = '0; d_o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_o_valid", 65'(o_valid), 65'(0));
        chk("reset_result", result, 65'(0));
        chk("reset_o_ovf", 65'(o_ovf), 65'(0));
        chk("reset_i_ready", 65'(i_ready), 65'(1));
        chk("reset_d_result", 65'(d_result), 65'(0));
        @(posedge clk);
        #1;

        send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 65'h1_0000_0000_0000_0000, 1'b0, 1'b1);
        send(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 65'h0_8000_0000_0000_0000, 1'b1, 1'b1);
        send(1'b1, 64'd5, 64'd7, 65'h0_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
        send(1'b1, 64'd7, 64'd5, 65'h1_0000_0000_0000_0002, 1'b0, 1'b1);
        send(1'b1, 64'h8000_0000_0000_0000, 64'h1, 65'h1_7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        send(1'b1, 64'h0, 64'h0, 65'h1_0000_0000_0000_0000, 1'b0, 1'b1);
        send(1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 65'h0_0001_0000_0001_0000, 1'b0, 1'b1);
        send(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000, 1'b1, 1'b1);
        idle(1);
        drain();

        bp_en = 1'b1;
        repeat (16) send_rand();
        i_valid = 1'b0;
        drain();
        bp_en = 1'b0;
        idle(3);

        base = vcnt;
        send(1'b0, 64'd1, 64'd2, 65'h3, 1'b0, 1'b1);
        idle(2);
        send(1'b1, 64'd10, 64'd3, 65'h1_0000_0000_0000_0007, 1'b0, 1'b1);
        idle(2);
        send(1'b0, 64'h1234, 64'h1111, 65'h2345, 1'b0, 1'b1);
        idle(8);
        chk("bubble_pulses", 65'(vcnt - base), 65'(3));
        drain();

        send(1'b0, 64'd100, 64'd1, 65'd101, 1'b0, 1'b0);
        send(1'b0, 64'd200, 64'd2, 65'd202, 1'b0, 1'b0);
        send(1'b0, 64'd300, 64'd3, 65'd303, 1'b0, 1'b0);
        rst = 1'b1;
        i_valid = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = vcnt;
        idle(10);
        chk("reset_flush_outputs", 65'(vcnt - base), 65'(0));
        chk("reset_flush_result", result, 65'(0));

        dsend(1'b0, 16'hFFFF, 16'h0001, 17'h1_0000, 1'b0);
        dsend(1'b0, 16'h7FFF, 16'h0001, 17'h0_8000, 1'b1);
        dsend(1'b1, 16'h0003, 16'h0005, 17'h0_FFFE, 1'b0);
        dsend(1'b1, 16'h8000, 16'h0001, 17'h1_7FFF, 1'b1);
        d_i_valid = 1'b0;
        drain();
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
